// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int FQ_XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Default-width queue entry; the top re-declares it when XLEN differs.
  typedef struct packed {
    logic [31:0]        instr;
    logic [FQ_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory, redirect and decode handshake bundle of fetch_queue.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pcplus4;
  logic [CW-1:0]   count;

  modport master (
    input  redirect, redirect_pc, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4, count
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4, count
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular DEPTH-entry buffer of fetched instructions with flush.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  CW      = $clog2(DEPTH + 1),
  parameter type entry_t = fetch_entry_t
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + AW'(1);
      if (pop_i)  head_d = head_q + AW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_i) mem_q[tail_q] <= push_data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC, credit-limited one-cycle imem reads and decode queue with redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;

  logic            resp_valid, bypass_hit, pop, issue;
  logic            fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occ_after;
  entry_t          fifo_head, resp_entry;
  logic [1:0]      unused_redirect_lsbs;

  assign unused_redirect_lsbs = bus.redirect_pc[1:0];

  assign resp_valid = inflight_q & ~kill_q;
  assign resp_entry = '{instr: bus.imem_rdata, pc: inflight_pc_q};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = resp_valid & fifo_empty & ~bus.redirect & ~rst;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bus.instr_valid   = ~rst & ~bus.redirect & (~fifo_empty | bypass_hit);
  assign bus.instr         = bypass_hit ? bus.imem_rdata : fifo_head.instr;
  assign bus.instr_pc      = bypass_hit ? inflight_pc_q : fifo_head.pc;
  assign bus.instr_pcplus4 = bus.instr_pc + XLEN'(INSTR_BYTES);
  assign bus.count         = fifo_count;

  assign pop       = bus.instr_valid & bus.instr_ready;
  assign fifo_pop  = pop & ~bypass_hit;
  assign fifo_push = resp_valid & ~(bypass_hit & bus.instr_ready);

  // Credit: counting the outstanding read keeps a push from ever landing on a full queue.
  assign occ_after = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = ~rst & ~bus.redirect & (occ_after < (CW+1)'(DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    kill_d        = 1'b0;
    if (bus.redirect) begin
      pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
      kill_d = 1'b1;
    end else if (issue) begin
      pc_d          = pc_q + XLEN'(INSTR_BYTES);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VEC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  fetch_queue_fifo #(
    .DEPTH   (DEPTH),
    .CW      (CW),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.redirect),
    .push_i      (fifo_push),
    .push_data_i (resp_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run against a PC-stream scoreboard.
`timescale 1ns/1ps
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hA5C3_0000;
  endfunction

  // Memory answers every request exactly one cycle later with address-tagged data.
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? memWord(bus.imem_addr) : NOP;

  // Scoreboard: PCs issued and not yet delivered, plus the next expected fetch address.
  logic [31:0] issuedQ[$];
  logic [31:0] expFetch = RESET_VEC;
  logic        obsReq, obsValid;
  logic [31:0] obsAddr, obsInstr, obsPc, obsPc4;
  logic [2:0]  obsCount;
  logic [31:0] expAddr, delPc;
  bit          delivered, delOrphan;
  int          deliveries = 0;

  task automatic tick();
    #1;
    obsReq = bus.imem_req;      obsAddr = bus.imem_addr;
    obsValid = bus.instr_valid; obsInstr = bus.instr;
    obsPc = bus.instr_pc;       obsPc4 = bus.instr_pcplus4;
    obsCount = bus.count;
    expAddr = expFetch; delivered = 0; delOrphan = 0;
    if (rst) begin
      issuedQ.delete(); expFetch = RESET_VEC;
    end else if (bus.redirect) begin
      issuedQ.delete(); expFetch = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (obsValid === 1'b1 && bus.instr_ready) begin
        delivered = 1; deliveries++;
        if (issuedQ.size() == 0) delOrphan = 1;
        else delPc = issuedQ.pop_front();
      end
      if (obsReq === 1'b1) begin
        issuedQ.push_back(expFetch);
        expFetch = expFetch + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (obsReq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b want 0", obsReq); end
      vectors++; if (obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", obsValid); end
      vectors++; if (obsCount !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", obsCount); end
    end
  endtask

  task automatic test_startup();
    logic [31:0] e;
    rst = 1'b0; bus.instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = 32'(4 * i);
      vectors++; if (obsReq !== 1'b1 || obsAddr !== e) begin miscompares++; $display("[TB] FAIL start_addr c%0d: got %b/%h want 1/%h", i, obsReq, obsAddr, e); end
      vectors++; if (obsValid !== (i >= LAT)) begin miscompares++; $display("[TB] FAIL start_valid c%0d: got %b want %b", i, obsValid, (i >= LAT)); end
      if (i >= LAT) begin
        e = 32'(4 * (i - LAT));
        vectors++; if (obsPc !== e || obsPc4 !== e + 32'd4 || obsInstr !== memWord(e)) begin
          miscompares++; $display("[TB] FAIL start_pc c%0d: got pc %h pc4 %h instr %h want %h %h %h", i, obsPc, obsPc4, obsInstr, e, e + 32'd4, memWord(e)); end
      end
      vectors++; if (!(obsCount <= 3'd1)) begin miscompares++; $display("[TB] FAIL start_count c%0d: got %0d want <=1", i, obsCount); end
    end
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    rst = 1'b1; bus.instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obsReq === 1'b1) reqs++;
      if (i >= LAT) begin
        vectors++; if (obsValid !== 1'b1 || obsPc !== 32'h0 || obsInstr !== memWord(32'h0)) begin
          miscompares++; $display("[TB] FAIL hold_head c%0d: got %b %h %h want 1 0 %h", i, obsValid, obsPc, obsInstr, memWord(32'h0)); end
      end
    end
    vectors++; if (reqs != 4) begin miscompares++; $display("[TB] FAIL bp_issues: got %0d want 4", reqs); end
    vectors++; if (obsCount !== 3'd4) begin miscompares++; $display("[TB] FAIL bp_count: got %0d want 4", obsCount); end
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (obsValid !== 1'b1 || obsPc !== 32'(4 * k)) begin
        miscompares++; $display("[TB] FAIL bp_drain k%0d: got %b %h want 1 %h", k, obsValid, obsPc, 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect_kill();
    logic [31:0] e;
    rst = 1'b1; bus.instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    tick();
    vectors++; if (obsCount !== 3'd3) begin miscompares++; $display("[TB] FAIL kill_pre_count: got %0d want 3", obsCount); end
    vectors++; if (obsReq !== 1'b0 || obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_cycle: got req %b valid %b want 0 0", obsReq, obsValid); end
    bus.redirect = 1'b0; bus.instr_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 0) begin
        vectors++; if (obsCount !== 3'd0) begin miscompares++; $display("[TB] FAIL kill_count: got %0d want 0", obsCount); end
      end
      e = 32'h100 + 32'(4 * j);
      vectors++; if (obsReq !== 1'b1 || obsAddr !== e) begin miscompares++; $display("[TB] FAIL kill_addr j%0d: got %b/%h want 1/%h", j, obsReq, obsAddr, e); end
      vectors++; if (obsValid !== (j >= LAT)) begin miscompares++; $display("[TB] FAIL kill_valid j%0d: got %b want %b", j, obsValid, (j >= LAT)); end
      if (j >= LAT) begin
        e = 32'h100 + 32'(4 * (j - LAT));
        vectors++; if (obsPc !== e || obsInstr !== memWord(e)) begin miscompares++; $display("[TB] FAIL kill_pc j%0d: got %h %h want %h %h", j, obsPc, obsInstr, e, memWord(e)); end
      end
    end
  endtask

  task automatic test_redirect(input logic [31:0] firstPc, input logic [31:0] lastPc, input bit twice, input string tag);
    logic [31:0] e;
    bus.instr_ready = 1'b1;
    for (int r = 0; r < (twice ? 2 : 1); r++) begin
      bus.redirect = 1'b1; bus.redirect_pc = (r == 0) ? firstPc : lastPc;
      tick();
      vectors++; if (obsReq !== 1'b0 || obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_cycle%0d: got req %b valid %b want 0 0", tag, r, obsReq, obsValid); end
    end
    bus.redirect = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      e = lastPc + 32'(4 * j);
      vectors++; if (obsReq !== 1'b1 || obsAddr !== e) begin miscompares++; $display("[TB] FAIL %s_addr j%0d: got %b/%h want 1/%h", tag, j, obsReq, obsAddr, e); end
      vectors++; if (obsValid !== (j >= LAT)) begin miscompares++; $display("[TB] FAIL %s_valid j%0d: got %b want %b", tag, j, obsValid, (j >= LAT)); end
      if (j >= LAT) begin
        e = lastPc + 32'(4 * (j - LAT));
        vectors++; if (obsPc !== e || obsPc4 !== e + 32'd4 || obsInstr !== memWord(e)) begin
          miscompares++; $display("[TB] FAIL %s_pc j%0d: got %h %h %h want %h %h %h", tag, j, obsPc, obsPc4, obsInstr, e, e + 32'd4, memWord(e)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_redirect(32'h0000_0200, 32'h0000_0300, 1'b1, "double");
  endtask

  task automatic test_wrap();
    test_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0, "wrap");
  endtask

  task automatic test_reset_midstream();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0500;
    tick();
    vectors++; if (obsReq !== 1'b0 || obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_cycle: got req %b valid %b want 0 0", obsReq, obsValid); end
    rst = 1'b0; bus.redirect = 1'b0;
    tick();
    vectors++; if (obsCount !== 3'd0 || obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_state: got count %0d valid %b want 0 0", obsCount, obsValid); end
    vectors++; if (obsReq !== 1'b1 || obsAddr !== RESET_VEC) begin miscompares++; $display("[TB] FAIL rstmid_fetch: got %b/%h want 1/%h", obsReq, obsAddr, RESET_VEC); end
  endtask

  task automatic test_random();
    bit curRst, curRedir, holdPrev = 0;
    logic [31:0] prevPc, prevInstr;
    int startDel = deliveries;
    for (int c = 0; c < 400; c++) begin
      curRst = ($urandom_range(0, 149) == 0);
      curRedir = ($urandom_range(0, 19) == 0);
      rst = curRst; bus.redirect = curRedir; bus.redirect_pc = $urandom;
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (curRst || curRedir) begin
        vectors++; if (obsReq !== 1'b0 || obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_quiet c%0d: got req %b valid %b want 0 0", c, obsReq, obsValid); end
      end else if (obsReq === 1'b1) begin
        vectors++; if (obsAddr !== expAddr) begin miscompares++; $display("[TB] FAIL rnd_addr c%0d: got %h want %h", c, obsAddr, expAddr); end
      end
      if (delivered) begin
        vectors++; if (delOrphan) begin miscompares++; $display("[TB] FAIL rnd_orphan c%0d: got pc %h want no delivery", c, obsPc); end
        else if (obsPc !== delPc || obsPc4 !== delPc + 32'd4 || obsInstr !== memWord(delPc)) begin
          miscompares++; $display("[TB] FAIL rnd_deliver c%0d: got %h %h %h want %h %h %h", c, obsPc, obsPc4, obsInstr, delPc, delPc + 32'd4, memWord(delPc)); end
      end
      if (holdPrev && !curRst && !curRedir) begin
        vectors++; if (obsValid !== 1'b1 || obsPc !== prevPc || obsInstr !== prevInstr) begin
          miscompares++; $display("[TB] FAIL rnd_stable c%0d: got %b %h %h want 1 %h %h", c, obsValid, obsPc, obsInstr, prevPc, prevInstr); end
      end
      vectors++; if (!(obsCount <= 3'(DEPTH))) begin miscompares++; $display("[TB] FAIL rnd_count c%0d: got %0d want <=%0d", c, obsCount, DEPTH); end
      holdPrev = (obsValid === 1'b1) && !bus.instr_ready && !curRst && !curRedir;
      prevPc = obsPc; prevInstr = obsInstr;
    end
    vectors++; if (deliveries - startDel < 100) begin miscompares++; $display("[TB] FAIL rnd_progress: got %0d deliveries want >=100", deliveries - startDel); end
    rst = 1'b0; bus.redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect_kill();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end replacing the fixed PC register / +4 adder / fetch-to-decode register chain. Owns the fetch PC, issues one-cycle-latency instruction-memory reads, buffers returned instructions with their PC in a DEPTH-entry queue, and hands them to decode over a valid/ready handshake. Execute-stage redirects flush the queue and kill the in-flight read, so decode can stall without losing fetched work.

## Interface
- XLEN, 32: address/PC width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_VEC, 32'h0000_0000 (XLEN bits): first fetch address after reset.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous and active-high.
- REDIRECT  in  1  taken branch/jump from execute.
- REDIRECT_PC  in  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- IMEM_REQ  out  1  read request this cycle; memory always accepts.
- IMEM_ADDR  out  XLEN  word address of request (bits [1:0]=0).
- IMEM_RDATA  in  32  read data, valid exactly one cycle after the request.
- INSTR_VALID  out  1  head entry valid.
- INSTR_READY  in  1  decode accepts head entry.
- INSTR  out  32  head instruction.
- INSTR_PC  out  XLEN  PC of head instruction.
- INSTR_PCPLUS4  out  XLEN  INSTR_PC + 4, modulo 2^XLEN.
- COUNT  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- State: fetch PC, in-flight flag with PC of outstanding read, kill flag, queue with head/tail pointers and occupancy.
- Pop: INSTR_VALID & INSTR_READY; head advances at edge.
- Issue rule: IMEM_REQ = !RST & !REDIRECT & (occupancy + inflight − pop < DEPTH). On issue, fetch PC += 4 (wraps modulo 2^XLEN) and in-flight set with issued PC.
- Response: cycle after issue, IMEM_RDATA and saved PC pushed at tail unless kill flag set; in-flight clears.
- Credit rule guarantees push never hits a full queue; push and pop in the same cycle leave occupancy unchanged.
- Redirect (REDIRECT=1): queue emptied, in-flight read marked killed (its data discarded next cycle), fetch PC <= {REDIRECT_PC[XLEN-1:2],2'b00}, no request this cycle. INSTR_VALID forced 0 that cycle; any READY is ignored.
- Back-to-back redirects: last one wins; each kills prior work.
- RST overrides REDIRECT and all handshakes.

## Timing
- Reset values (cycle after RST sampled high): fetch PC=RESET_VEC, queue empty, COUNT=0, INSTR_VALID=0, in-flight=0, kill=0; IMEM_REQ=0 while RST high.
- First request in first cycle with RST low, IMEM_ADDR=RESET_VEC.
- Request-to-INSTR_VALID latency: 2 cycles (1 with bypass, see Configuration).
- Redirect penalty: request to REDIRECT_PC issued cycle after REDIRECT; INSTR_VALID with that PC 2 cycles later.
- Steady state with READY held high: one instruction per cycle, COUNT stays ≤1.
- READY low: queue fills to DEPTH then IMEM_REQ holds 0; no instruction lost or duplicated.
- INSTR/INSTR_PC/INSTR_PCPLUS4 stable while INSTR_VALID=1 and READY=0.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when queue is empty and an unkilled response arrives, it drives INSTR/INSTR_PC/INSTR_VALID combinationally the same cycle; if READY, it is consumed and not written. Latency 1 cycle; COUNT excludes the bypassed entry.
- Undefined: all responses written to queue first; INSTR_* purely registered; latency 2 cycles.

## Structure
- Package fetch_queue_pkg: fetch_entry_t struct {instr[31:0], pc[XLEN-1:0]}, INSTR_BYTES=4 constant, NOP=32'h0000_0013 constant for bench use.
- Sub-module fetch_queue_fifo: parametrised storage (DEPTH × fetch_entry_t) with push/pop/flush, pointers, occupancy; top level holds PC, credit logic, kill logic, bypass.

## Test plan
- Reset release, READY=1, memory returns addr-tagged data: IMEM_ADDR 0,4,8,… each cycle; INSTR_PC 0 at cycle 2 (1 with bypass), then +4 per cycle, INSTR_PCPLUS4=INSTR_PC+4.
- READY=0 for 10 cycles, DEPTH=4: COUNT reaches 4, IMEM_REQ=0 after 4 issues; on READY=1 PCs 0,4,8,12,16 delivered in order, no gaps.
- REDIRECT with REDIRECT_PC=32'h0000_0103 while queue holds 3 and read in flight: COUNT=0 next cycle, killed data never appears, next IMEM_ADDR=32'h0000_0100.
- Redirect in two consecutive cycles (0x200 then 0x300): only 0x300 stream delivered.
- Fetch PC at 32'hFFFF_FFFC: next IMEM_ADDR 32'h0000_0000; INSTR_PCPLUS4 of that entry = 0.
- RST asserted mid-stream with REDIRECT high: next cycle COUNT=0, INSTR_VALID=0, first fetch after release at RESET_VEC.
